sha_sched_ctrl: RTL and testbench
=================================

SHA_SCHED_CTRL -- requirements
Module: sha_sched_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the message/schedule word width.
REQ-002 SHALL have parameter DELAY_W, default 32, giving the width of the schedule-unit delay configuration.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port abort, input, 1, synchronous return to FILL, discarding buffered words.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W), forming the message-word handshake.
REQ-007 SHALL have ports unit_run (output, 1), unit_delay0 (output, DELAY_W), unit_in0 (output, DATA_W) and unit_out0 (input, DATA_W), connecting to the message-schedule unit.
REQ-008 SHALL have ports w_valid (output, 1), w_data (output, DATA_W), w_idx (output, 6) and w_last (output, 1), forming the schedule-word stream with no backpressure.
REQ-009 SHALL have port blk_done, output, 1, a one-cycle pulse after W[63].

Function
REQ-010 SHALL implement states FILL, ISSUE, STREAM.
REQ-011 SHALL, in FILL, drive in_ready=1 and store in_data into buffer slot cnt on each in_valid&in_ready cycle, then increment cnt.
REQ-012 SHALL, when the 16th word is accepted, move to ISSUE on the next edge, with in_ready=0 from that edge on.
REQ-013 SHALL, in ISSUE, assert unit_run=1 for exactly one cycle (cycle 0), then move to STREAM with t=0.
REQ-014 SHALL drive unit_delay0 to constant 0, because the timing in REQ-015 and REQ-016 depends on it.
REQ-015 SHALL, in STREAM cycle t+1 for t=0..15, drive unit_in0=buf[t], w_data=buf[t], w_idx=t and w_valid=1.
REQ-016 SHALL, in STREAM cycle t+1 for t=16..63, drive w_data=unit_out0, w_idx=t and w_valid=1, with no additional register stage.
REQ-017 SHALL drive unit_in0 to 0 outside the cycles in REQ-015.
REQ-018 SHALL assert w_last=1 only when w_idx=63, and SHALL pulse blk_done in the following cycle.
REQ-019 SHALL return from STREAM to FILL with cnt=0 on the edge after w_idx=63, with in_ready=1 starting in the blk_done cycle.
REQ-020 SHALL make each block exactly 64 consecutive w_valid cycles, with no gaps.
REQ-021 SHALL ignore in_valid while in_ready=0.
REQ-022 SHALL treat abort as highest priority in any state: next state FILL, cnt=0, w_valid=0, no blk_done.
REQ-023 SHALL let abort override an in_valid accept in the same cycle, so the word is dropped.
REQ-024 SHALL use a 6-bit t counter that stops at 63 and never wraps into a second pass.

Reset
REQ-025 SHALL, on rst, set state=FILL, cnt=0, t=0, in_ready=1 (combinational from state), and unit_run=0, w_valid=0, w_last=0, blk_done=0, unit_in0=0, w_data=0, w_idx=0.
REQ-026 SHALL NOT reset buffer contents.
REQ-027 SHALL treat rst mid-STREAM as equivalent to abort, with no further w_valid.

Structure
REQ-028 SHALL place NUM_IN_WORDS=16, NUM_SCHED_WORDS=64 and the state enumeration in shared package sha_pkg.
REQ-029 SHALL implement the 16 x DATA_W buffer as sub-module sha_word_buf (write port: en, addr, data; combinational read port: addr).
REQ-030 SHALL NOT instantiate the schedule unit; the unit is wired alongside the controller at the next level up.

Verification
REQ-031 SHALL cover the "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) with the real unit attached -> w_idx 0..63 contiguous, W16=0x61626380, W17=0x000F0000, w_last with idx 63, blk_done one cycle later.
REQ-032 SHALL cover input with in_valid toggling 1,0,1,0 -> 16 words captured in order, and unit_run pulses once, exactly one cycle after the 16th accept.
REQ-033 SHALL cover back-to-back blocks with words offered during STREAM -> in_ready=0 throughout STREAM, and the second block starts streaming at w_idx 0 with its own words.
REQ-034 SHALL cover abort at w_idx=20 -> w_valid=0 next cycle, no blk_done, in_ready=1, and the next 16 words produce a correct new block.
REQ-035 SHALL cover abort coincident with the 8th accept -> that word is dropped, and cnt=0 afterwards.
REQ-036 SHALL cover rst asserted asynchronously mid-FILL and mid-STREAM -> all outputs take their REQ-025 reset values immediately, with no unit_run until 16 new words are accepted.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared constants and state encoding for the SHA message-schedule controller.
package sha_pkg;

  localparam int NUM_IN_WORDS    = 16;
  localparam int NUM_SCHED_WORDS = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_STREAM = 2'd2;

endpackage

// File: rtl/sha_word_buf.sv
// 16-entry message-word buffer: one synchronous write port, one combinational read port.
module sha_word_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every slot is written before it is read in a block.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sha_sched_ctrl.sv
// Collects 16 message words, kicks the schedule unit, then streams W[0..63]
// (buffered words first, unit output after) as one gap-free burst.
module sha_sched_ctrl
  import sha_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               unit_run,
  output logic [DELAY_W-1:0] unit_delay0,
  output logic [DATA_W-1:0]  unit_in0,
  input  logic [DATA_W-1:0]  unit_out0,
  output logic               w_valid,
  output logic [DATA_W-1:0]  w_data,
  output logic [5:0]         w_idx,
  output logic               w_last,
  output logic               blk_done
);

  localparam logic [3:0] CNT_LAST = 4'(NUM_IN_WORDS - 1);
  localparam logic [5:0] T_LAST   = 6'(NUM_SCHED_WORDS - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic        blk_done_q, blk_done_d;

  logic              wr_en;
  logic              streaming;
  logic              from_buf;
  logic [DATA_W-1:0] buf_rd;

  assign in_ready  = (state_q == ST_FILL);
  // abort drops a word offered in the same cycle
  assign wr_en     = in_valid & in_ready & ~abort;
  assign streaming = (state_q == ST_STREAM);
  assign from_buf  = streaming & (t_q[5:4] == 2'b00);

  sha_word_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_IN_WORDS)
  ) u_word_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt_q),
    .wr_data (in_data),
    .rd_addr (t_q[3:0]),
    .rd_data (buf_rd)
  );

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    blk_done_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (wr_en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_ISSUE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_ISSUE: begin
        t_d     = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // t saturates at the last index and the block ends there
        if (t_q == T_LAST) begin
          state_d    = ST_FILL;
          cnt_d      = '0;
          t_d        = '0;
          blk_done_d = 1'b1;
        end else begin
          t_d = t_q + 6'd1;
        end
      end
      default: state_d = ST_FILL;
    endcase
    if (abort) begin
      state_d    = ST_FILL;
      cnt_d      = '0;
      t_d        = '0;
      blk_done_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      t_q        <= '0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_q        <= t_d;
      blk_done_q <= blk_done_d;
    end
  end

  // Stream outputs are decoded straight from state so unit_out0 reaches w_data unregistered.
  assign unit_run    = (state_q == ST_ISSUE);
  assign unit_delay0 = '0;
  assign unit_in0    = from_buf ? buf_rd : '0;
  assign w_valid     = streaming;
  assign w_idx       = streaming ? t_q : 6'd0;
  assign w_data      = from_buf ? buf_rd : (streaming ? unit_out0 : '0);
  assign w_last      = streaming & (t_q == T_LAST);
  assign blk_done    = blk_done_q;

endmodule

// File: tb/tb_sha_sched_ctrl.sv
// Directed bench for sha_sched_ctrl with a behavioural schedule unit (delay 0) attached.
module tb_sha_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        unit_run;
  logic [31:0] unit_delay0;
  logic [31:0] unit_in0;
  logic [31:0] unit_out0;
  logic        w_valid;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        blk_done;

  int tests_run = 0;
  int fails     = 0;
  int run_count = 0;
  int blk_count = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  always #5 clk = ~clk;

  sha_sched_ctrl #(.DATA_W(32), .DELAY_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .unit_run    (unit_run),
    .unit_delay0 (unit_delay0),
    .unit_in0    (unit_in0),
    .unit_out0   (unit_out0),
    .w_valid     (w_valid),
    .w_data      (w_data),
    .w_idx       (w_idx),
    .w_last      (w_last),
    .blk_done    (blk_done)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Schedule unit with zero delay: loads 16 words after unit_run, then self-extends.
  logic [31:0] win [16];
  int          ucnt;
  logic        uact;
  assign unit_out0 = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uact <= 1'b0;
      ucnt <= 0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (unit_run) begin
      uact <= 1'b1;
      ucnt <= 0;
    end else if (uact) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= (ucnt < 16) ? unit_in0 : unit_out0;
      ucnt    <= ucnt + 1;
    end
  end

  always @(negedge clk) begin
    if (unit_run) run_count++;
    if (blk_done) blk_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_expected();
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_unit_run"}, unit_run, 0);
    check({tag, "_w_valid"}, w_valid, 0);
    check({tag, "_w_last"}, w_last, 0);
    check({tag, "_blk_done"}, blk_done, 0);
    check({tag, "_unit_in0"}, unit_in0, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_w_idx"}, w_idx, 0);
    check({tag, "_delay0"}, unit_delay0, 0);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after the last accept edge.
  task automatic send_words(input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 32'hdead_beef;
        tick();
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      #1;
      check($sformatf("fill_ready_%0d", i), in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Entered in the ISSUE cycle at posedge+1.
  task automatic issue_and_stream(input bit junk, input int abort_at, input int rst_at);
    int r0, b0;
    r0 = run_count;
    b0 = blk_count;
    build_expected();
    if (junk) begin
      in_valid = 1'b1;
      in_data  = $urandom;
    end
    #1;
    check("issue_unit_run", unit_run, 1);
    check("issue_in_ready", in_ready, 0);
    tick();
    for (int t = 0; t < 64; t++) begin
      if (junk) in_data = $urandom;
      #1;
      got_w[t] = w_data;
      check($sformatf("w_valid_%0d", t), w_valid, 1);
      check($sformatf("w_idx_%0d", t), w_idx, t);
      check($sformatf("w_data_%0d", t), w_data, exp_w[t]);
      check($sformatf("unit_in0_%0d", t), unit_in0, (t < 16) ? msg[t] : 32'h0);
      check($sformatf("w_last_%0d", t), w_last, t == 63);
      check($sformatf("stream_ready_%0d", t), in_ready, 0);
      if (t == abort_at) begin
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_w_valid", w_valid, 0);
        check("abort_blk_done", blk_done, 0);
        check("abort_in_ready", in_ready, 1);
        tick();
        tick();
        check("abort_no_blk_done", blk_count, b0);
        return;
      end
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1 check_idle("rst_stream");
        #2 rst = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("rst_stream_no_blk_done", blk_count, b0);
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("done_pulse", blk_done, 1);
    check("done_in_ready", in_ready, 1);
    check("done_w_valid", w_valid, 0);
    check("run_once", run_count, r0 + 1);
    tick();
    check("done_cleared", blk_done, 0);
  endtask

  task automatic random_msg();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  initial begin
    #1;
    check_idle("reset");
    #6 rst = 1'b0;
    tick();
    check_idle("post_reset");

    // "abc" padded block
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h6162_6380;
    msg[15] = 32'h0000_0018;
    send_words(0, 16, 1'b0);
    issue_and_stream(1'b0, -1, -1);
    check("abc_w16", got_w[16], 32'h6162_6380);
    check("abc_w17", got_w[17], 32'h000F_0000);

    // in_valid toggling 1,0,1,0
    random_msg();
    send_words(0, 16, 1'b1);
    issue_and_stream(1'b0, -1, -1);

    // back-to-back blocks with words offered during STREAM
    random_msg();
    send_words(0, 16, 1'b0);
    issue_and_stream(1'b1, -1, -1);
    random_msg();
    send_words(0, 16, 1'b0);
    issue_and_stream(1'b0, -1, -1);

    // abort at w_idx 20, then a fresh block
    random_msg();
    send_words(0, 16, 1'b0);
    issue_and_stream(1'b0, 20, -1);
    random_msg();
    send_words(0, 16, 1'b0);
    issue_and_stream(1'b0, -1, -1);

    // abort coincident with the 8th accept
    random_msg();
    send_words(0, 7, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hbad0_bad0;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort8_in_ready", in_ready, 1);
    check("abort8_unit_run", unit_run, 0);
    random_msg();
    send_words(0, 16, 1'b0);
    issue_and_stream(1'b0, -1, -1);

    // asynchronous rst mid-FILL
    random_msg();
    send_words(0, 5, 1'b0);
    #2 rst = 1'b1;
    #1 check_idle("rst_fill");
    #2 rst = 1'b0;
    tick();

    // asynchronous rst mid-STREAM, then 16 new words needed before unit_run
    send_words(0, 16, 1'b0);
    issue_and_stream(1'b0, -1, 30);
    begin
      int r0;
      r0 = run_count;
      random_msg();
      send_words(0, 15, 1'b0);
      tick();
      check("rst_no_early_run", run_count, r0);
      check("rst_still_fill", in_ready, 1);
      send_words(15, 1, 1'b0);
      issue_and_stream(1'b0, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
